pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and branch-resolution stage of the single-cycle CPU. It sits directly downstream of the ALU: it consumes the ALU's ZERO flag together with decoded branch/jump controls and the instruction's 8-bit offset, and produces the next instruction address for instruction memory. It holds the PC across instruction- and data-memory busywait stalls and counts retired instructions.

## Interface
- PC_W, 32: program-counter width in bits.
- OFF_W, 8: branch/jump offset width in bits; offset is signed and in instruction words.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the retired-instruction counter.

- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BRANCH  in  1  current instruction is beq (taken when ZERO=1).
- BRANCH_NE  in  1  current instruction is bne (taken when ZERO=0).
- JUMP  in  1  current instruction is an unconditional jump.
- OFFSET  in  OFF_W  signed word offset from the instruction.
- ZERO  in  1  ALU zero flag for the current instruction.
- IMEM_BUSYWAIT  in  1  instruction memory not ready.
- DMEM_BUSYWAIT  in  1  data memory not ready.
- PC  out  PC_W  current instruction address (registered).
- PC_VALID  out  1  PC is presented for a fetch (low in BOOT).
- TAKEN  out  1  current instruction redirects control flow (combinational).
- STALL  out  1  PC is held this cycle (combinational).
- RETIRED  out  CNT_W  count of PC advances since reset (registered).

## Operation
- PC_NEXT_SEQ = PC + 4. TARGET = PC + 4 + (sign_extend(OFFSET) << 2); both modulo 2^PC_W.
- TAKEN = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO). JUMP dominates; BRANCH and BRANCH_NE both high is illegal (TAKEN then follows the OR above, no error reported).
- STALL = IMEM_BUSYWAIT | DMEM_BUSYWAIT, gated to 0 in BOOT.
- State machine, states BOOT, RUN, WAIT:
  - BOOT: entered asynchronously on RESET low. PC=RESET_PC, RETIRED=0, PC_VALID=0. First rising edge with RESET high → RUN; PC unchanged.
  - RUN: PC_VALID=1. If STALL: hold PC and RETIRED, go to WAIT. Else PC ← TAKEN ? TARGET : PC_NEXT_SEQ, RETIRED ← RETIRED+1, stay RUN.
  - WAIT: PC_VALID=1, PC and RETIRED held. When STALL drops, same edge performs the RUN update using inputs present that cycle, go to RUN. Stays WAIT while STALL high.
- Control inputs and ZERO are stable during a stall because PC is held; no capture of branch decision is required.
- RETIRED wraps from 2^CNT_W−1 to 0.
- RESET low in any state, including mid-stall: immediate return to BOOT, all outputs to reset values.

## Timing
- Reset values: PC=RESET_PC, PC_VALID=0, RETIRED=0; TAKEN and STALL follow inputs (STALL=0 in BOOT).
- PC latency: one cycle from decision to new PC; one PC update per non-stalled RUN/WAIT cycle.
- First fetch address after reset release is RESET_PC, presented with PC_VALID=1 from the cycle after BOOT.
- Busywait of N cycles holds PC for exactly N edges; update occurs on the first edge with STALL low.
- TAKEN and STALL are combinational from inputs; no combinational path from any input to PC or RETIRED.

## Structure
- Shared package cpu_pkg: state enum (BOOT, RUN, WAIT), PC_STEP=4 constant, instruction-word shift constant (2).
- One sub-module: branch_target (combinational sign-extend, shift, add producing TARGET and PC_NEXT_SEQ), instantiated once.

## Test plan
- Reset then release, no stalls, no branches → PC: 0 (PC_VALID=0), 0, 4, 8, 12; RETIRED 0,0,1,2,3.
- At PC=8, BRANCH=1, ZERO=1, OFFSET=8'hFE → TAKEN=1, next PC=8+4−8=4; same with ZERO=0 → PC=12.
- At PC=16, BRANCH_NE=1, ZERO=0, OFFSET=3 → PC=32; JUMP=1 with OFFSET=8'h80 from PC=0x200 → PC=0x004.
- At PC=20 with JUMP=1, OFFSET=2, DMEM_BUSYWAIT high 3 cycles → PC stays 20 three edges, STALL=1, then PC=32; RETIRED increments once.
- PC=0xFFFFFFFC, sequential → PC=0; RETIRED at 0xFFFF advances to 0.
- RESET pulsed low mid-WAIT (IMEM_BUSYWAIT high) → PC=0, PC_VALID=0, RETIRED=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-stage state encoding and address-step constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } pc_state_e;

  // Byte distance between consecutive instructions.
  localparam int PC_STEP = 4;

  // Word offsets become byte offsets by shifting left this many bits.
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/branch_target.sv
// Combinational next-address generation: sequential PC and branch/jump target.
module branch_target
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OFF_W-1:0] i_offset,
  output logic [PC_W-1:0]  o_pc_next_seq,
  output logic [PC_W-1:0]  o_target
);

  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_off_bytes;

  // Sign-extend the word offset, convert to bytes, add relative to PC+4.
  always_comb begin
    w_off_ext     = {{(PC_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};
    w_off_bytes   = w_off_ext << WORD_SHIFT;
    o_pc_next_seq = i_pc + PC_W'(PC_STEP);
    o_target      = o_pc_next_seq + w_off_bytes;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter and branch resolution with busywait stall handling and a
// retired-instruction counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_BOOT | after reset; PC = RESET_PC, no fetch presented, no stalls
//   ST_RUN  | fetching; PC advances every edge unless a busywait is seen
//   ST_WAIT | memory busy; PC and RETIRED held until busywait drops
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BRANCH,
  input  logic              BRANCH_NE,
  input  logic              JUMP,
  input  logic [OFF_W-1:0]  OFFSET,
  input  logic              ZERO,
  input  logic              IMEM_BUSYWAIT,
  input  logic              DMEM_BUSYWAIT,
  output logic [PC_W-1:0]   PC,
  output logic              PC_VALID,
  output logic              TAKEN,
  output logic              STALL,
  output logic [CNT_W-1:0]  RETIRED
);

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;
  logic [PC_W-1:0]  w_pc_next_seq;
  logic [PC_W-1:0]  w_target;
  logic             w_busy;
  logic             w_advance;

  branch_target #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_branch_target (
    .i_pc          (r_pc),
    .i_offset      (OFFSET),
    .o_pc_next_seq (w_pc_next_seq),
    .o_target      (w_target)
  );

  assign w_busy = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign TAKEN  = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_BOOT;
    else        r_state <= w_state_next;
  end

  // Next-state logic: RUN and WAIT differ only in whether a stall is ongoing.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN:  w_state_next = w_busy ? ST_WAIT : ST_RUN;
      ST_WAIT: w_state_next = w_busy ? ST_WAIT : ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  // Output decode: stalls are ignored in BOOT, otherwise PC advances when not stalled.
  always_comb begin
    PC_VALID  = 1'b0;
    STALL     = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_RUN, ST_WAIT: begin
        PC_VALID  = 1'b1;
        STALL     = w_busy;
        w_advance = ~w_busy;
      end
      default: ;
    endcase
  end

  // PC and retired counter update on each non-stalled RUN/WAIT edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc      <= RESET_PC;
      r_retired <= '0;
    end else if (w_advance) begin
      r_pc      <= TAKEN ? w_target : w_pc_next_seq;
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign PC      = r_pc;
  assign RETIRED = r_retired;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BRANCH, BRANCH_NE, JUMP, ZERO;
  logic [7:0]  OFFSET;
  logic        IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic [31:0] PC;
  logic        PC_VALID, TAKEN, STALL;
  logic [15:0] RETIRED;

  int checks = 0;
  int failures = 0;

  pc_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BRANCH        (BRANCH),
    .BRANCH_NE     (BRANCH_NE),
    .JUMP          (JUMP),
    .OFFSET        (OFFSET),
    .ZERO          (ZERO),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
    .PC            (PC),
    .PC_VALID      (PC_VALID),
    .TAKEN         (TAKEN),
    .STALL         (STALL),
    .RETIRED       (RETIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        br;
    logic        bne;
    logic        jmp;
    logic [7:0]  off;
    logic        zero;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic bne, input logic jmp,
                       input logic [7:0] off, input logic zero,
                       input logic imem, input logic dmem);
    BRANCH = br; BRANCH_NE = bne; JUMP = jmp; OFFSET = off; ZERO = zero;
    IMEM_BUSYWAIT = imem; DMEM_BUSYWAIT = dmem;
  endtask

  initial begin
    // Continuous program run starting at PC=0 after reset release.
    vecs[0]  = '{br:0, bne:0, jmp:0, off:8'h00, zero:0, exp_taken:0, exp_pc:32'd4,      exp_ret:16'd1};
    vecs[1]  = '{br:0, bne:0, jmp:0, off:8'h00, zero:0, exp_taken:0, exp_pc:32'd8,      exp_ret:16'd2};
    vecs[2]  = '{br:1, bne:0, jmp:0, off:8'hFE, zero:1, exp_taken:1, exp_pc:32'd4,      exp_ret:16'd3};
    vecs[3]  = '{br:0, bne:0, jmp:0, off:8'h00, zero:0, exp_taken:0, exp_pc:32'd8,      exp_ret:16'd4};
    vecs[4]  = '{br:1, bne:0, jmp:0, off:8'hFE, zero:0, exp_taken:0, exp_pc:32'd12,     exp_ret:16'd5};
    vecs[5]  = '{br:0, bne:0, jmp:0, off:8'h00, zero:1, exp_taken:0, exp_pc:32'd16,     exp_ret:16'd6};
    vecs[6]  = '{br:0, bne:1, jmp:0, off:8'h03, zero:0, exp_taken:1, exp_pc:32'd32,     exp_ret:16'd7};
    vecs[7]  = '{br:0, bne:1, jmp:0, off:8'h03, zero:1, exp_taken:0, exp_pc:32'd36,     exp_ret:16'd8};
    vecs[8]  = '{br:1, bne:1, jmp:0, off:8'h01, zero:1, exp_taken:1, exp_pc:32'd44,     exp_ret:16'd9};
    vecs[9]  = '{br:0, bne:0, jmp:1, off:8'h74, zero:0, exp_taken:1, exp_pc:32'h200,    exp_ret:16'd10};
    vecs[10] = '{br:0, bne:0, jmp:1, off:8'h80, zero:1, exp_taken:1, exp_pc:32'h004,    exp_ret:16'd11};
    vecs[11] = '{br:1, bne:0, jmp:1, off:8'h03, zero:0, exp_taken:1, exp_pc:32'd20,     exp_ret:16'd12};

    // Reset with busywait asserted: STALL must stay low in BOOT.
    RESET = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 1, 0);
    #12;
    chk("boot_pc", PC, 32'd0);
    chk("boot_valid", {31'd0, PC_VALID}, 32'd0);
    chk("boot_retired", {16'd0, RETIRED}, 32'd0);
    chk("boot_stall", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;
    chk("boot_hold_valid", {31'd0, PC_VALID}, 32'd0);

    @(negedge CLK);
    RESET = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    @(posedge CLK); #1;
    chk("first_fetch_pc", PC, 32'd0);
    chk("first_fetch_valid", {31'd0, PC_VALID}, 32'd1);
    chk("first_fetch_retired", {16'd0, RETIRED}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      drive(vecs[i].br, vecs[i].bne, vecs[i].jmp, vecs[i].off, vecs[i].zero, 0, 0);
      #1;
      chk($sformatf("v%0d_taken", i), {31'd0, TAKEN}, {31'd0, vecs[i].exp_taken});
      chk($sformatf("v%0d_stall", i), {31'd0, STALL}, 32'd0);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("v%0d_retired", i), {16'd0, RETIRED}, {16'd0, vecs[i].exp_ret});
      chk($sformatf("v%0d_valid", i), {31'd0, PC_VALID}, 32'd1);
    end

    // Jump at PC=20 held by a 3-cycle data-memory busywait.
    @(negedge CLK);
    drive(0, 0, 1, 8'h02, 0, 0, 1);
    #1;
    chk("stall_flag", {31'd0, STALL}, 32'd1);
    chk("stall_taken", {31'd0, TAKEN}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("stall%0d_pc", k), PC, 32'd20);
      chk($sformatf("stall%0d_retired", k), {16'd0, RETIRED}, 32'd12);
      chk($sformatf("stall%0d_valid", k), {31'd0, PC_VALID}, 32'd1);
    end
    @(negedge CLK);
    DMEM_BUSYWAIT = 1'b0;
    #1;
    chk("unstall_flag", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;
    chk("unstall_pc", PC, 32'd32);
    chk("unstall_retired", {16'd0, RETIRED}, 32'd13);

    // Jump backwards past zero, then sequential wrap of the PC.
    @(negedge CLK);
    drive(0, 0, 1, 8'hF6, 0, 0, 0);
    @(posedge CLK); #1;
    chk("wrap_jump_pc", PC, 32'hFFFF_FFFC);
    @(negedge CLK);
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    @(posedge CLK); #1;
    chk("wrap_seq_pc", PC, 32'd0);
    chk("wrap_seq_retired", {16'd0, RETIRED}, 32'd15);

    // Run sequentially until the retired counter reaches its maximum, then wrap.
    for (int n = 0; n < 65520; n++) @(posedge CLK);
    #1;
    chk("ret_max", {16'd0, RETIRED}, 32'h0000_FFFF);
    chk("ret_max_pc", PC, 32'd65520 * 4);
    @(posedge CLK); #1;
    chk("ret_wrap", {16'd0, RETIRED}, 32'd0);
    @(posedge CLK); #1;
    chk("ret_after_wrap", {16'd0, RETIRED}, 32'd1);

    // Enter WAIT on an instruction-memory busywait, then reset between edges.
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    chk("wait_hold_retired", {16'd0, RETIRED}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst_pc", PC, 32'd0);
    chk("async_rst_valid", {31'd0, PC_VALID}, 32'd0);
    chk("async_rst_retired", {16'd0, RETIRED}, 32'd0);
    chk("async_rst_stall", {31'd0, STALL}, 32'd0);

    @(negedge CLK);
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'b0;
    @(posedge CLK); #1;
    chk("rerun_pc", PC, 32'd0);
    chk("rerun_valid", {31'd0, PC_VALID}, 32'd1);
    @(posedge CLK); #1;
    chk("rerun_adv_pc", PC, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
